// File: rtl/led_cpu_with_rom.sv
// LED sequencer: a tiny ROM-driven CPU that holds each pattern for a programmable
// number of prescaled dwell units, then steps or jumps to the next instruction.
module led_cpu_with_rom #(
    parameter int unsigned FREQ = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] outPattern
);

    logic [7:0]  topAddr;
    logic [7:0]  top_addr_d;

    logic [31:0] presc_q;
    logic [31:0] presc_d;
    logic [6:0]  dwell_q;
    logic [6:0]  dwell_d;

    logic        tick;
    logic        last_unit;
    logic [6:0]  dwell_len;

    logic [23:0] rom_word;
    logic        ins_jmp;
    logic [6:0]  ins_cnt;
    logic [7:0]  ins_pattern;
    logic [7:0]  ins_target;

    // Word layout: {jmp, cnt[6:0], pattern[7:0], target[7:0]}
    function automatic logic [23:0] rom_lookup(input logic [7:0] addr);
        logic [23:0] word;
        case (addr)
            8'h00:   word = {1'b0, 7'd1, 8'hAA, 8'h00};
            8'h01:   word = {1'b0, 7'd2, 8'h55, 8'h00};
            8'h02:   word = {1'b0, 7'd3, 8'hCC, 8'h00};
            8'h03:   word = {1'b0, 7'd1, 8'h33, 8'h00};
            8'h04:   word = {1'b0, 7'd3, 8'hFF, 8'h00};
            8'h05:   word = {1'b0, 7'd2, 8'h00, 8'h00};
            8'h06:   word = {1'b1, 7'd1, 8'h0A, 8'h0A};
            8'h0A:   word = {1'b0, 7'd2, 8'h7F, 8'h00};
            8'h0B:   word = {1'b0, 7'd1, 8'h80, 8'h00};
            8'h0C:   word = {1'b0, 7'd1, 8'hFF, 8'h00};
            8'h0D:   word = {1'b0, 7'd2, 8'h00, 8'h00};
            8'h0E:   word = {1'b0, 7'd3, 8'h11, 8'h00};
            8'h0F:   word = {1'b1, 7'd1, 8'h00, 8'h00};
            default: word = {1'b0, 7'd1, 8'h00, 8'h00};
        endcase
        return word;
    endfunction

    always_comb begin
        rom_word    = rom_lookup(topAddr);
        ins_jmp     = rom_word[23];
        ins_cnt     = rom_word[22:16];
        ins_pattern = rom_word[15:8];
        ins_target  = rom_word[7:0];
    end

    // Pattern is a pure function of the PC, so reset shows address 0x00 at once.
    assign outPattern = ins_pattern;

    always_comb begin
        tick    = (presc_q == FREQ);
        presc_d = tick ? 32'd0 : presc_q + 32'd1;
    end

    // A zero dwell count still occupies one unit.
    always_comb begin
        dwell_len = (ins_cnt == 7'd0) ? 7'd1 : ins_cnt;
        last_unit = (dwell_q == dwell_len - 7'd1);
    end

    always_comb begin
        top_addr_d = topAddr;
        dwell_d    = dwell_q;
        if (tick) begin
            if (last_unit) begin
                top_addr_d = ins_jmp ? ins_target : topAddr + 8'd1;
                dwell_d    = 7'd0;
            end else begin
                dwell_d    = dwell_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            topAddr <= 8'h00;
            dwell_q <= 7'd0;
            presc_q <= 32'd0;
        end else begin
            topAddr <= top_addr_d;
            dwell_q <= dwell_d;
            presc_q <= presc_d;
        end
    end

endmodule

// File: tb/tb_led_cpu_with_rom.sv
// Directed bench for the LED sequencer: full program pass, loop-back, mid-run reset,
// prescaled timing on a FREQ=3 copy, and walk through unused ROM addresses.
`timescale 1ns/1ps
module tb_led_cpu_with_rom;

    logic       clk;
    logic       rst;
    logic [7:0] pat1;
    logic [7:0] pat4;

    int errs   = 0;
    int checks = 0;

    led_cpu_with_rom #(.FREQ(0)) dut (
        .clk(clk), .rst(rst), .outPattern(pat1)
    );

    led_cpu_with_rom #(.FREQ(3)) dut4 (
        .clk(clk), .rst(rst), .outPattern(pat4)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check8(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, act, exp);
        end
    endtask

    task automatic at(input int t);
        if (int'($time) < t) #(t - int'($time));
    endtask

    initial begin
        rst = 1'b0;

        at(21);
        check8("rst_pat", pat1, 8'hAA);
        check8("rst_addr", dut.topAddr, 8'h00);
        // Release just after the 30 ns edge so the 40 ns edge is dwell cycle 1.
        at(31);
        rst = 1'b1;
        #0.5;
        check8("p1_AA", pat1, 8'hAA);

        at(41);  check8("p1_55", pat1, 8'h55);
        at(51);  check8("p1_55_hold", pat1, 8'h55);
        check8("f3_AA_hold", pat4, 8'hAA);
        at(61);  check8("p1_CC", pat1, 8'hCC);
        check8("f3_AA_last", pat4, 8'hAA);
        at(71);  check8("f3_55", pat4, 8'h55);
        at(81);  check8("p1_CC_hold", pat1, 8'hCC);
        at(91);  check8("p1_33", pat1, 8'h33);
        at(101); check8("p1_FF", pat1, 8'hFF);
        at(121); check8("p1_FF_hold", pat1, 8'hFF);
        at(131); check8("p1_00", pat1, 8'h00);
        at(141); check8("p1_00_hold", pat1, 8'h00);
        check8("f3_55_last", pat4, 8'h55);
        at(151); check8("p1_0A", pat1, 8'h0A);
        check8("f3_CC", pat4, 8'hCC);
        at(161); check8("p1_jmp_pat", pat1, 8'h7F);
        check8("p1_jmp_addr", dut.topAddr, 8'h0A);
        at(171); check8("p1_7F_hold", pat1, 8'h7F);
        at(181); check8("p1_80", pat1, 8'h80);
        at(191); check8("p1_FF2", pat1, 8'hFF);
        at(201); check8("p1_00b", pat1, 8'h00);
        at(221); check8("p1_11", pat1, 8'h11);
        at(241); check8("p1_11_hold", pat1, 8'h11);
        at(251); check8("p1_00c", pat1, 8'h00);
        at(261); check8("p1_loop_pat", pat1, 8'hAA);
        check8("p1_loop_addr", dut.topAddr, 8'h00);

        // Second pass is the first shifted by one program period (230 ns).
        at(271); check8("p2_55", pat1, 8'h55);
        at(291); check8("p2_CC", pat1, 8'hCC);
        at(381); check8("p2_0A", pat1, 8'h0A);
        at(391); check8("p2_jmp_pat", pat1, 8'h7F);
        check8("p2_jmp_addr", dut.topAddr, 8'h0A);
        at(481); check8("p2_00c", pat1, 8'h00);
        at(491); check8("p2_loop_pat", pat1, 8'hAA);
        check8("p2_loop_addr", dut.topAddr, 8'h00);

        // Third pass: 7F dwell spans 620..639; abort it mid-dwell.
        at(621); check8("p3_7F", pat1, 8'h7F);
        at(625);
        rst = 1'b0;
        #0.1;
        check8("mid_rst_addr", dut.topAddr, 8'h00);
        check8("mid_rst_pat", pat1, 8'hAA);
        at(631);
        rst = 1'b1;
        #0.5;
        check8("mid_rel_AA", pat1, 8'hAA);
        at(641); check8("mid_55", pat1, 8'h55);
        at(661); check8("mid_CC", pat1, 8'hCC);

        // Unused addresses: fresh reset, then park the PC at 0x07.
        at(701);
        rst = 1'b0;
        at(711);
        rst = 1'b1;
        force dut.topAddr = 8'h07;
        #0.5;
        check8("un07_pat", pat1, 8'h00);
        check8("un07_addr", dut.topAddr, 8'h07);
        release dut.topAddr;
        at(721); check8("un08_addr", dut.topAddr, 8'h08);
        check8("un08_pat", pat1, 8'h00);
        at(731); check8("un09_addr", dut.topAddr, 8'h09);
        at(741); check8("un0A_addr", dut.topAddr, 8'h0A);
        check8("un0A_pat", pat1, 8'h7F);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/led_cpu_with_rom.md
LED_CPU_WITH_ROM -- requirements
Module: led_cpu_with_rom

Interface
REQ-001 Parameter FREQ, default 0: prescaler value; one dwell unit SHALL equal FREQ+1 clock cycles.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 outPattern  output  8  LED pattern of the instruction at the current program counter.
REQ-005 Only one clock SHALL exist; reset SHALL be asynchronous and active-low.

Function
REQ-006 The block SHALL contain an 8-bit program counter register named topAddr, reachable by hierarchical reference from a bench.
REQ-007 The block SHALL contain a 256-entry x 24-bit ROM, read asynchronously, addressed by topAddr.
REQ-008 ROM word layout SHALL be [23] jmp, [22:16] cnt (dwell units), [15:8] pattern, [7:0] target.
REQ-009 outPattern SHALL equal ROM[topAddr].pattern combinationally, with no register stage, including while rst is low.
REQ-010 A prescaler SHALL count 0..FREQ and assert an internal tick in the cycle it equals FREQ, then wrap to 0; with FREQ=0, tick SHALL assert every cycle.
REQ-011 A 7-bit dwell counter SHALL increment on each tick while the current instruction is active.
REQ-012 An instruction SHALL stay active for max(cnt,1) dwell units; cnt=0 SHALL be treated as 1.
REQ-013 On the tick that completes the dwell, topAddr SHALL load target if jmp=1, else topAddr+1. The dwell counter SHALL clear to 0 on the same edge.
REQ-014 Jumps SHALL add zero overhead cycles: the target instruction's pattern SHALL appear on the same edge that leaves the jumping instruction.
REQ-015 topAddr+1 from 0xFF SHALL wrap to 0x00.
REQ-016 The prescaler SHALL free-run; it SHALL NOT reset on instruction change.
REQ-017 ROM contents SHALL be the following (address: pattern, cnt, jmp->target):
- 00: AA, 1
- 01: 55, 2
- 02: CC, 3
- 03: 33, 1
- 04: FF, 3
- 05: 00, 2
- 06: 0A, 1, jmp->0A
- 0A: 7F, 2
- 0B: 80, 1
- 0C: FF, 1
- 0D: 00, 2
- 0E: 11, 3
- 0F: 00, 1, jmp->00
- All other addresses: pattern 00, cnt 1, jmp 0.
REQ-018 Design size SHALL be 120-400 lines of RTL. The ROM SHALL be a case statement or an initialized array.

Reset
REQ-019 While rst=0: topAddr=0x00, dwell counter=0, prescaler=0. outPattern SHALL therefore read 0xAA.
REQ-020 Reset assertion SHALL take effect immediately, without waiting for a clock edge. Mid-program reset SHALL abort the dwell and return to address 0x00.
REQ-021 After rst rises, the first rising edge SHALL count as dwell cycle 1 of address 0x00.

Verification
REQ-022 Setup: FREQ=0, 10 ns clock with rising edges at 10, 20, 30 ns..., rst low until 30 ns. Required outPattern with first-change times:
- AA at 31
- 55 at 40
- CC at 60
- 33 at 90
- FF at 100
- 00 at 130
- 0A at 150
- 7F at 160
- 80 at 180
- FF at 190
- 00 at 200
- 11 at 220
- 00 at 250
- AA at 260
REQ-023 Jump check: at 161 ns, outPattern=7F and topAddr=0x0A. At 261 ns, outPattern=AA and topAddr=0x00, confirming the loop back. The second pass SHALL repeat the first pass timing.
REQ-024 Mid-run reset: drive rst=0 at 175 ns (inside the 7F dwell) -> topAddr=00 and outPattern=AA within the same time step. After release, the sequence restarts from AA with 1-cycle dwell.
REQ-025 Prescaler: FREQ=3 -> every dwell time is scaled x4 (AA 4 cycles, 55 8 cycles, CC 12 cycles, ...). The pattern order is unchanged.
REQ-026 Unused-address check: force topAddr=0x07 -> outPattern=00, advancing 07->08->09->0A at one address per cycle.
